muller_c_driver: RTL and testbench

Clocked 4-phase stimulus sequencer that sits directly upstream of the N-input Muller C-element. It drives the element's N inputs and monitors its output through a synchroniser. Each handshake raises the inputs one at a time, waits for the element output to rise, then lowers them one at a time and waits for it to fall. It measures response latency, counts completed handshakes, and flags protocol violations (early output change, timeout, bad initial state).

---
 rtl/muller_c_driver.sv | 190 +++++++++++++++++++
 tb/tb_muller_c_driver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muller_c_driver.sv
// 4-phase stimulus sequencer for an N-input Muller C-element: raises inputs one
// at a time, waits for the synced output, lowers them, and reports latency/errors.
module muller_c_driver #(
  parameter int N       = 6,
  parameter int STEP    = 2,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16,
  parameter int LAT_W   = 8
) (
`ifdef USE_POWER_PINS
  inout  wire               vccd1,
  inout  wire               vssd1,
`endif
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        num_hs,
  input  logic              c_out,
  output logic [N-1:0]      drive,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  hs_count,
  output logic [LAT_W-1:0]  last_lat
);

  // state   | meaning
  // IDLE    | waiting for start
  // RISE    | setting drive bits 0..N-1, STEP cycles apart
  // WAIT_HI | all inputs high, waiting for synced output to rise
  // FALL    | clearing drive bits 0..N-1, STEP cycles apart
  // WAIT_LO | all inputs low, waiting for synced output to fall
  // ERR     | protocol violation, drive frozen until start
  typedef enum logic [2:0] {S_IDLE, S_RISE, S_WAIT_HI, S_FALL, S_WAIT_LO, S_ERR} state_t;

  localparam int IDX_W  = $clog2(N);
  localparam int STEP_W = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int SAT_W  = ((TMO_W > LAT_W) ? TMO_W : LAT_W) + 1;
  localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP - 1);

  state_t             state, state_d;
  logic               co_meta, co_s;
  logic [N-1:0]       drive_d;
  logic [IDX_W-1:0]   bit_idx, bit_idx_d;
  logic [STEP_W-1:0]  step_cnt, step_cnt_d;
  logic [TMO_W-1:0]   lat_cnt, lat_cnt_d;
  logic [7:0]         num_hs_q, num_hs_d;
  logic               done_d, err_d;
  logic [1:0]         err_code_d;
  logic [CNT_W-1:0]   hs_count_d, hs_next;
  logic [LAT_W-1:0]   last_lat_d, lat_sat;
  logic [SAT_W-1:0]   lat_ext;
  logic               bit_last, early, resp, finish;

  assign busy = (state == S_RISE) || (state == S_WAIT_HI) ||
                (state == S_FALL) || (state == S_WAIT_LO);

  always_comb begin
    state_d    = state;
    drive_d    = drive;
    bit_idx_d  = bit_idx;
    step_cnt_d = step_cnt;
    lat_cnt_d  = lat_cnt;
    num_hs_d   = num_hs_q;
    done_d     = 1'b0;
    err_d      = err;
    err_code_d = err_code;
    hs_count_d = hs_count;
    last_lat_d = last_lat;

    hs_next  = hs_count + CNT_W'(1);
    bit_last = (bit_idx == IDX_W'(N - 1));
    early    = (state == S_RISE) ? co_s : !co_s;
    resp     = (state == S_WAIT_HI) ? co_s : !co_s;
    finish   = ((num_hs_q != 8'd0) && (hs_next == CNT_W'(num_hs_q))) ||
               ((num_hs_q == 8'd0) && stop);
    // Latency saturates instead of wrapping when LAT_W is narrower than the timer.
    lat_ext  = SAT_W'(lat_cnt);
    lat_sat  = (lat_ext > SAT_W'({LAT_W{1'b1}})) ? {LAT_W{1'b1}} : lat_ext[LAT_W-1:0];

    case (state)
      S_IDLE: begin
        if (start) begin
          if (co_s) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end else begin
            state_d    = S_RISE;
            hs_count_d = '0;
            num_hs_d   = num_hs;
            drive_d    = N'(1);
            bit_idx_d  = IDX_W'(1);
            step_cnt_d = STEP_LOAD;
          end
        end
      end
      S_RISE, S_FALL: begin
        if (early) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = 2'd2;
        end else if (step_cnt != '0) begin
          step_cnt_d = step_cnt - STEP_W'(1);
        end else begin
          for (int i = 0; i < N; i++)
            if (bit_idx == IDX_W'(i)) drive_d[i] = (state == S_RISE);
          bit_idx_d  = bit_idx + IDX_W'(1);
          step_cnt_d = STEP_LOAD;
          if (bit_last) begin
            state_d   = (state == S_RISE) ? S_WAIT_HI : S_WAIT_LO;
            lat_cnt_d = '0;
          end
        end
      end
      S_WAIT_HI, S_WAIT_LO: begin
        if (resp) begin
          last_lat_d = lat_sat;
          bit_idx_d  = IDX_W'(1);
          step_cnt_d = STEP_LOAD;
          if (state == S_WAIT_HI) begin
            state_d    = S_FALL;
            drive_d[0] = 1'b0;
          end else begin
            hs_count_d = hs_next;
            if (finish) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d    = S_RISE;
              drive_d[0] = 1'b1;
            end
          end
        end else if (lat_cnt == TMO_W'(TIMEOUT - 1)) begin
          state_d    = S_ERR;
          err_d      = 1'b1;
          err_code_d = 2'd3;
        end else begin
          lat_cnt_d = lat_cnt + TMO_W'(1);
        end
      end
      S_ERR: begin
        // Drive stays frozen for inspection; it is released on acknowledge.
        if (start) begin
          state_d    = S_IDLE;
          err_d      = 1'b0;
          err_code_d = 2'd0;
          drive_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= S_IDLE;
      co_meta  <= 1'b0;
      co_s     <= 1'b0;
      drive    <= '0;
      bit_idx  <= '0;
      step_cnt <= '0;
      lat_cnt  <= '0;
      num_hs_q <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
      hs_count <= '0;
      last_lat <= '0;
    end else begin
      state    <= state_d;
      co_meta  <= c_out;
      co_s     <= co_meta;
      drive    <= drive_d;
      bit_idx  <= bit_idx_d;
      step_cnt <= step_cnt_d;
      lat_cnt  <= lat_cnt_d;
      num_hs_q <= num_hs_d;
      done     <= done_d;
      err      <= err_d;
      err_code <= err_code_d;
      hs_count <= hs_count_d;
      last_lat <= last_lat_d;
    end
  end

endmodule

// File: tb/tb_muller_c_driver.sv
// Directed bench for muller_c_driver with an ideal C-element model of
// programmable delay; expected cycle counts are computed by hand.
module tb_muller_c_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  num_hs = 8'd0;
  logic        c_out = 1'b0;
  logic [5:0]  drive;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [15:0] hs_count;
  logic [7:0]  last_lat;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int e0 = 0;
  int done_cnt = 0;
  int at;

  // C-element model: output goes high when all inputs high, low when all low,
  // then appears on c_out dly cycles later unless overridden.
  logic hist [32];
  logic c_state = 1'b0;
  int   dly = 0;
  bit   force_en = 1'b0;
  logic force_val = 1'b0;

  muller_c_driver #(.N(6), .STEP(2), .TIMEOUT(64), .CNT_W(16), .LAT_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start    (start),
    .stop     (stop),
    .num_hs   (num_hs),
    .c_out    (c_out),
    .drive    (drive),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .hs_count (hs_count),
    .last_lat (last_lat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) hist[i] = 1'b0;
      c_state = 1'b0;
    end else begin
      for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
      if (&drive) c_state = 1'b1;
      else if (drive == 6'd0) c_state = 1'b0;
      hist[0] = c_state;
    end
    c_out = force_en ? force_val : hist[dly];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (done) begin
      done_cnt++;
      check("done_err_excl", {31'd0, err}, 32'd0);
    end
  end

  // Called at a negedge; leaves the bench at the negedge after the start edge.
  task automatic start_run(input logic [7:0] nh);
    num_hs = nh;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    e0    = cyc;
  endtask

  // which: 0 waits for done, 1 for err. Returns cycles since start edge, or -1.
  task automatic wait_for(input int which, input int bound, output int when);
    when = -1;
    for (int i = 0; i < bound; i++) begin
      if ((which == 0 && done) || (which == 1 && err)) begin
        when = cyc - e0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_drive", drive, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_hs", hs_count, 0);
    check("rst_lat", last_lat, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single handshake, d=3
    dly = 3;
    done_cnt = 0;
    start_run(8'd1);
    check("t1_busy", busy, 1);
    for (int k = 0; k < 6; k++) begin
      check("t1_rise_a", drive, (32'd1 << (k + 1)) - 1);
      @(negedge clk);
      check("t1_rise_b", drive, (32'd1 << (k + 1)) - 1);
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("t1_fall", drive, 6'h3C);
    wait_for(0, 100, at);
    check("t1_done_cyc", at, 32);
    check("t1_hs", hs_count, 1);
    check("t1_lat", last_lat, 5);
    check("t1_err", err, 0);
    check("t1_drive", drive, 0);
    check("t1_busy_end", busy, 0);
    repeat (3) @(negedge clk);
    check("t1_done_cnt", done_cnt, 1);

    // four handshakes, d=0, num_hs changed mid-run
    dly = 0;
    done_cnt = 0;
    start_run(8'd4);
    num_hs = 8'd1;
    wait_for(0, 200, at);
    check("t2_done_cyc", at, 104);
    check("t2_hs", hs_count, 4);
    check("t2_lat", last_lat, 2);
    repeat (3) @(negedge clk);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_busy", busy, 0);
    check("t2_drive", drive, 0);

    // free run, stop during third FALL
    done_cnt = 0;
    start_run(8'd0);
    repeat (68) @(negedge clk);
    check("t3_busy", busy, 1);
    stop = 1'b1;
    wait_for(0, 200, at);
    stop = 1'b0;
    check("t3_done_cyc", at, 78);
    check("t3_hs", hs_count, 3);
    repeat (3) @(negedge clk);
    check("t3_done_cnt", done_cnt, 1);

    // output stuck low -> timeout
    done_cnt = 0;
    force_en = 1'b1;
    force_val = 1'b0;
    start_run(8'd1);
    wait_for(1, 120, at);
    check("t4_err_cyc", at, 74);
    check("t4_code", err_code, 3);
    check("t4_drive", drive, 6'h3F);
    check("t4_busy", busy, 0);
    check("t4_done_cnt", done_cnt, 0);
    start_run(8'd1);
    check("t4_clr_err", err, 0);
    check("t4_clr_code", err_code, 0);
    repeat (2) @(negedge clk);
    check("t4_idle", busy, 0);
    force_en = 1'b0;
    repeat (10) @(negedge clk);

    // output forced high during RISE -> early
    start_run(8'd1);
    repeat (4) @(negedge clk);
    check("t5_drive7", drive, 6'h07);
    force_en = 1'b1;
    force_val = 1'b1;
    wait_for(1, 40, at);
    check("t5_err_cyc", at, 8);
    check("t5_code", err_code, 2);
    check("t5_drive", drive, 6'h0F);
    start_run(8'd1);
    check("t5_clr", err, 0);
    repeat (2) @(negedge clk);

    // output high at start -> init error (force still high)
    repeat (4) @(negedge clk);
    start_run(8'd1);
    check("t5b_err", err, 1);
    check("t5b_code", err_code, 1);
    check("t5b_drive", drive, 0);
    check("t5b_busy", busy, 0);
    start_run(8'd1);
    check("t5b_clr_code", err_code, 0);
    force_en = 1'b0;
    repeat (10) @(negedge clk);

    // reset in WAIT_HI, then clean run
    dly = 20;
    start_run(8'd1);
    repeat (12) @(negedge clk);
    check("t6_busy", busy, 1);
    check("t6_drive_pre", drive, 6'h3F);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_drive", drive, 0);
    check("t6_busy0", busy, 0);
    check("t6_done", done, 0);
    check("t6_err", err, 0);
    check("t6_code", err_code, 0);
    check("t6_hs", hs_count, 0);
    check("t6_lat", last_lat, 0);
    repeat (40) @(negedge clk);
    dly = 1;
    done_cnt = 0;
    start_run(8'd2);
    wait_for(0, 200, at);
    check("t6_done_cyc", at, 56);
    check("t6_hs2", hs_count, 2);
    check("t6_lat2", last_lat, 3);
    check("t6_err2", err, 0);
    repeat (3) @(negedge clk);
    check("t6_done_cnt", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
